rvc_asap_5pl_vga_mem_arb: RTL and testbench

- Single-port access arbiter for the VGA frame memory inside the 5pl memory wrap.
- Shares one synchronous memory port between two requesters:
  - the core data path, for stores and loads in the VGA window at 0x3000;
  - the VGA raster fetch engine.
- VGA fetch is real-time and has default priority. A starvation FSM guarantees the core a grant within MAX_WAIT cycles.
- Also keeps a saturating core-stall statistics counter.

---
 rtl/rvc_asap_5pl_vga_mem_arb.sv | 126 ++++++++++++
 tb/tb_rvc_asap_5pl_vga_mem_arb.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_asap_5pl_vga_mem_arb.sv
// Single-port arbiter for the VGA frame memory inside the 5pl memory wrap.
// The VGA raster fetch has default priority. A starvation FSM forces a core
// grant after MAX_WAIT consecutive denied core cycles. Read data returns one
// cycle after the grant and is steered to the requester that owned the read.
module rvc_asap_5pl_vga_mem_arb #(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic              Clock,
  input  logic              RstN,
  // core data path
  input  logic              CoreReq,
  input  logic              CoreWr,
  input  logic [ADDR_W-1:0] CoreAddr,
  input  logic [31:0]       CoreWrData,
  input  logic [3:0]        CoreByteEn,
  output logic              CoreGnt,
  output logic              CoreRdValid,
  output logic [31:0]       CoreRdData,
  // VGA raster fetch (read-only)
  input  logic              VgaReq,
  input  logic [ADDR_W-1:0] VgaAddr,
  output logic              VgaGnt,
  output logic              VgaRdValid,
  output logic [31:0]       VgaRdData,
  // shared synchronous memory port
  output logic              MemEn,
  output logic              MemWr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWrData,
  output logic [3:0]        MemByteEn,
  input  logic [31:0]       MemRdData,
  // statistics
  input  logic              ClrStat,
  output logic [CNT_W-1:0]  StallCnt
);

  typedef enum logic {PRI_VGA, PRI_CORE} pri_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_VGA} owner_e;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  pri_e             state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             core_denied;

  // Combinational grant: the priority state decides who wins a collision.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    CoreGnt = 1'b0;
    VgaGnt  = 1'b0;
    if (state_q == PRI_CORE) begin
      CoreGnt = CoreReq;
      VgaGnt  = VgaReq & ~CoreReq;
    end else begin
      VgaGnt  = VgaReq;
      CoreGnt = CoreReq & ~VgaReq;
    end
  end

  assign core_denied = CoreReq & ~CoreGnt;

  // Next-state logic for the starvation FSM, wait counter, read owner and stats.
  always_comb begin
    state_d = state_q;
    wait_d  = core_denied ? wait_q + 4'd1 : 4'd0;
    owner_d = OWN_NONE;
    stall_d = stall_q;

    case (state_q)
      PRI_VGA:  if (core_denied && wait_q == WAIT_LAST) state_d = PRI_CORE;
      PRI_CORE: if (CoreGnt || !CoreReq) state_d = PRI_VGA;
      default:  state_d = PRI_VGA;
    endcase

    // Only reads produce a return beat; VGA fetches are always reads.
    if (VgaGnt) owner_d = OWN_VGA;
    else if (CoreGnt && !CoreWr) owner_d = OWN_CORE;

    // Clear wins over increment; the counter holds at all-ones.
    if (ClrStat) stall_d = '0;
    else if (core_denied && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  // State registers; reset drops any read return still in flight.
  always_ff @(posedge Clock or negedge RstN) begin
    if (!RstN) begin
      state_q <= PRI_VGA;
      wait_q  <= 4'd0;
      owner_q <= OWN_NONE;
      stall_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      wait_q  <= wait_d;
      owner_q <= owner_d;
      stall_q <= stall_d;
    end
  end

  // Memory port follows whichever requester holds the grant this cycle.
  always_comb begin
    MemEn     = CoreGnt | VgaGnt;
    MemWr     = 1'b0;
    MemAddr   = CoreAddr;
    MemWrData = CoreWrData;
    MemByteEn = CoreByteEn;
    if (VgaGnt) begin
      MemAddr   = VgaAddr;
      MemByteEn = 4'hF;
    end else if (CoreGnt) begin
      MemWr = CoreWr;
    end
  end

  // Read data is shared; only the owner of last cycle's read sees valid.
  assign CoreRdValid = (owner_q == OWN_CORE);
  assign VgaRdValid  = (owner_q == OWN_VGA);
  assign CoreRdData  = MemRdData;
  assign VgaRdData   = MemRdData;
  assign StallCnt    = stall_q;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_mem_arb.sv
// Directed bench for the VGA memory arbiter: a cycle model predicts grants,
// port fields and the stall counter, and a queue carries expected read returns.
module tb_rvc_asap_5pl_vga_mem_arb;

  localparam int ADDR_W   = 16;
  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic        is_core;
    logic [31:0] data;
  } rd_exp_t;

  logic Clock = 1'b0;
  logic RstN;
  logic CoreReq, CoreWr, VgaReq, ClrStat;
  logic [ADDR_W-1:0] CoreAddr, VgaAddr;
  logic [31:0] CoreWrData, MemRdData;
  logic [3:0]  CoreByteEn;

  logic CoreGnt, CoreRdValid, VgaGnt, VgaRdValid, MemEn, MemWr;
  logic [31:0] CoreRdData, VgaRdData, MemWrData;
  logic [ADDR_W-1:0] MemAddr;
  logic [3:0]  MemByteEn;
  logic [15:0] StallCnt;

  // second instance: narrow statistics counter, same inputs
  logic s_cgnt, s_crv, s_vgnt, s_vrv, s_men, s_mwr;
  logic [31:0] s_crd, s_vrd, s_mwd;
  logic [ADDR_W-1:0] s_maddr;
  logic [3:0] s_mbe;
  logic [3:0] s_stall;

  int checks = 0;
  int errors = 0;

  rd_exp_t sb[$];
  logic        m_pri_core;
  logic [3:0]  m_wait;
  logic [15:0] m_stall;
  logic [3:0]  m_stall4;
  logic        last_vgnt, last_cgnt;
  logic [15:0] last_stall;
  logic [3:0]  last_stall4;
  logic [5:0]  vg_hist, cg_hist;

  always #5 Clock = ~Clock;

  rvc_asap_5pl_vga_mem_arb #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(16)) dut (
    .Clock(Clock), .RstN(RstN),
    .CoreReq(CoreReq), .CoreWr(CoreWr), .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
    .CoreByteEn(CoreByteEn), .CoreGnt(CoreGnt), .CoreRdValid(CoreRdValid), .CoreRdData(CoreRdData),
    .VgaReq(VgaReq), .VgaAddr(VgaAddr), .VgaGnt(VgaGnt), .VgaRdValid(VgaRdValid), .VgaRdData(VgaRdData),
    .MemEn(MemEn), .MemWr(MemWr), .MemAddr(MemAddr), .MemWrData(MemWrData), .MemByteEn(MemByteEn),
    .MemRdData(MemRdData), .ClrStat(ClrStat), .StallCnt(StallCnt)
  );

  rvc_asap_5pl_vga_mem_arb #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut4 (
    .Clock(Clock), .RstN(RstN),
    .CoreReq(CoreReq), .CoreWr(CoreWr), .CoreAddr(CoreAddr), .CoreWrData(CoreWrData),
    .CoreByteEn(CoreByteEn), .CoreGnt(s_cgnt), .CoreRdValid(s_crv), .CoreRdData(s_crd),
    .VgaReq(VgaReq), .VgaAddr(VgaAddr), .VgaGnt(s_vgnt), .VgaRdValid(s_vrv), .VgaRdData(s_vrd),
    .MemEn(s_men), .MemWr(s_mwr), .MemAddr(s_maddr), .MemWrData(s_mwd), .MemByteEn(s_mbe),
    .MemRdData(MemRdData), .ClrStat(ClrStat), .StallCnt(s_stall)
  );

  function automatic logic [31:0] mem_fn(input logic [ADDR_W-1:0] a);
    return (a == 16'h3140) ? 32'h1234_5678 : {~a, a};
  endfunction

  // Memory model: read data appears the cycle after a read enable.
  always @(posedge Clock)
    MemRdData <= (MemEn && !MemWr) ? mem_fn(MemAddr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return just after the next rising edge so the caller can drive inputs.
  task automatic step();
    rd_exp_t e;
    logic exp_c, exp_v, denied;
    @(negedge Clock);
    if (!RstN) begin
      check("rst_core_rvalid", CoreRdValid, 0);
      check("rst_vga_rvalid", VgaRdValid, 0);
      check("rst_stall", StallCnt, 0);
      check("rst_stall4", s_stall, 0);
      m_pri_core = 0; m_wait = 0; m_stall = 0; m_stall4 = 0;
      sb.delete();
    end else begin
      check("both_rvalid", CoreRdValid & VgaRdValid, 0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check(e.is_core ? "core_rvalid" : "vga_rvalid", e.is_core ? CoreRdValid : VgaRdValid, 1);
        check("other_rvalid", e.is_core ? VgaRdValid : CoreRdValid, 0);
        check(e.is_core ? "core_rdata" : "vga_rdata", e.is_core ? CoreRdData : VgaRdData, e.data);
      end else begin
        check("idle_core_rvalid", CoreRdValid, 0);
        check("idle_vga_rvalid", VgaRdValid, 0);
      end

      exp_v = m_pri_core ? (VgaReq & ~CoreReq) : VgaReq;
      exp_c = m_pri_core ? CoreReq : (CoreReq & ~VgaReq);
      check("vga_gnt", VgaGnt, exp_v);
      check("core_gnt", CoreGnt, exp_c);
      check("mem_en", MemEn, exp_v | exp_c);
      check("mem_wr", MemWr, exp_c & CoreWr);
      if (exp_v) begin
        check("mem_addr_vga", MemAddr, VgaAddr);
        check("mem_be_vga", MemByteEn, 4'hF);
        sb.push_back('{is_core: 1'b0, data: mem_fn(VgaAddr)});
      end else if (exp_c) begin
        check("mem_addr_core", MemAddr, CoreAddr);
        check("mem_be_core", MemByteEn, CoreByteEn);
        if (CoreWr) check("mem_wdata", MemWrData, CoreWrData);
        else sb.push_back('{is_core: 1'b1, data: mem_fn(CoreAddr)});
      end
      check("stall16", StallCnt, m_stall);
      check("stall4", s_stall, m_stall4);

      last_vgnt = VgaGnt; last_cgnt = CoreGnt;
      last_stall = StallCnt; last_stall4 = s_stall;

      denied = CoreReq & ~exp_c;
      if (!m_pri_core) m_pri_core = denied && (m_wait == 4'(MAX_WAIT - 1));
      else if (exp_c || !CoreReq) m_pri_core = 0;
      m_wait = denied ? m_wait + 4'd1 : 4'd0;
      if (ClrStat) begin
        m_stall = 0; m_stall4 = 0;
      end else if (denied) begin
        if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 4'd1;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    CoreReq = 0; CoreWr = 0; VgaReq = 0; ClrStat = 0;
  endtask

  initial begin
    RstN = 0; idle();
    CoreAddr = 16'h3000; CoreWrData = 0; CoreByteEn = 4'hF; VgaAddr = 16'h3100;
    m_pri_core = 0; m_wait = 0; m_stall = 0; m_stall4 = 0;
    step(); step();
    RstN = 1;
    step();

    // Reset mid-read: VGA read granted, reset lands in its return cycle.
    VgaReq = 1; VgaAddr = 16'h3200;
    step();
    idle(); RstN = 0;
    step(); step();
    RstN = 1;
    step(); step();
    // Priority after reset is VGA first.
    CoreReq = 1; CoreWr = 0; CoreAddr = 16'h3008; VgaReq = 1; VgaAddr = 16'h3210;
    step();
    check("post_rst_pri_vga", last_vgnt, 1);
    idle(); CoreReq = 1;
    step();
    idle(); step();

    // Lone core write.
    CoreReq = 1; CoreWr = 1; CoreAddr = 16'h3004; CoreWrData = 32'hA5A5_0F0F; CoreByteEn = 4'h3;
    step();
    check("lone_wr_gnt", last_cgnt, 1);
    idle(); step();

    // Lone VGA read returning 0x12345678.
    VgaReq = 1; VgaAddr = 16'h3140;
    step();
    idle(); step(); step();

    // Starvation with a core write: VGA held continuously.
    ClrStat = 1; step();
    ClrStat = 0;
    VgaReq = 1; VgaAddr = 16'h3300;
    CoreReq = 1; CoreWr = 1; CoreAddr = 16'h3010; CoreWrData = 32'h0BAD_F00D; CoreByteEn = 4'hC;
    for (int i = 0; i < 6; i++) begin
      step();
      vg_hist[i] = last_vgnt; cg_hist[i] = last_cgnt;
      if (i == 5) check("starve_stall", last_stall, 4);
      if (last_cgnt) CoreReq = 0;
      VgaAddr = VgaAddr + 16'h4;
    end
    check("starve_vga_pattern", vg_hist, 6'b101111);
    check("starve_core_pattern", cg_hist, 6'b010000);
    idle(); step(); step();

    // Interleaved reads: VGA fetches then a starved core read, one return per cycle.
    VgaReq = 1; VgaAddr = 16'h3400;
    CoreReq = 1; CoreWr = 0; CoreAddr = 16'h3020; CoreByteEn = 4'hF;
    for (int i = 0; i < 7; i++) begin
      step();
      if (last_cgnt) CoreReq = 0;
      VgaAddr = VgaAddr + 16'h4;
    end
    idle(); step(); step();

    // Saturation of the narrow counter, then clear while still denied.
    VgaReq = 1; VgaAddr = 16'h3500;
    CoreReq = 1; CoreWr = 1; CoreAddr = 16'h3030; CoreWrData = 32'h1111_2222;
    for (int i = 0; i < 25; i++) step();
    check("stall4_saturated", last_stall4, 4'hF);
    ClrStat = 1;
    step();
    ClrStat = 0;
    step();
    check("stall4_cleared", last_stall4, 0);
    step(); step();
    check("stall4_resumes", last_stall4 != 0, 1);
    idle(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
